// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and constants for the branch redirect unit
package branch_pkg;

    localparam int RQ_DATA_WIDTH = 32;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SQ_ID   = 2'd1,
        SQ_BOTH = 2'd2,
        SQ_EX   = 2'd3
    } squash_state_e;

    typedef struct packed {
        logic [RQ_DATA_WIDTH-1:0] fallback;
    } rq_entry_t;

endpackage

// File: rtl/recovery_queue.sv
// rtl/recovery_queue.sv - circular FIFO of mispredict fallback addresses
module recovery_queue
    import branch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  rq_entry_t push_entry,
    input  logic      pop,
    input  logic      clear,
    output logic      full,
    output logic      empty,
    output rq_entry_t head,
    output logic      overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    rq_entry_t        mem_q [DEPTH];
    rq_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign head     = mem_q[rd_ptr_q];
    // A pop in the same cycle frees a slot, so a push into a full queue still lands.
    assign pop_ok   = pop & ~empty;
    assign push_ok  = push & (~full | pop_ok);
    assign overflow = push & ~clear & ~push_ok;

    // Pointer, occupancy and storage update; clear discards everything at once.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/branch_redirect_unit.sv
// rtl/branch_redirect_unit.sv - fetch PC, redirect and flush control; BRANCH_STATS_EN adds counters
module branch_redirect_unit
    import branch_pkg::*;
#(
    parameter int                 PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                 IDX_WIDTH = 3,
    parameter int                 RQ_DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 id_is_branch,
    input  logic                 id_predict_taken,
    input  logic [PC_WIDTH-1:0]  id_branch_target,
    input  logic                 ex_branch_valid,
    input  logic                 ex_flush,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [IDX_WIDTH-1:0] id_pc_idx,
    output logic [IDX_WIDTH-1:0] ex_pc_idx,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 rq_overflow,
    output logic [31:0]          stat_branches,
    output logic [31:0]          stat_mispredicts
);

    squash_state_e       state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] id_pc_q, id_pc_d;
    logic [PC_WIDTH-1:0] ex_pc_q, ex_pc_d;
    logic                id_valid_q, id_valid_d;
    logic                ex_valid_q, ex_valid_d;
    logic                ovf_q, ovf_d;

    logic                squash_id;
    logic                squash_ex;
    logic                id_br;
    logic                mis;
    logic                pred_redirect;
    logic                advance;
    logic                rq_push;
    logic                rq_pop;
    logic                rq_full;
    logic                rq_empty;
    logic                rq_drop;
    rq_entry_t           rq_in;
    rq_entry_t           rq_head;
    logic [PC_WIDTH-1:0] head_pc;
    logic [PC_WIDTH-1:0] fallback_pc;
    logic                unused_ok;

    assign squash_id     = (state_q == SQ_ID) || (state_q == SQ_BOTH);
    assign squash_ex     = (state_q == SQ_BOTH) || (state_q == SQ_EX);
    assign id_br         = id_is_branch & ~squash_id;
    assign mis           = ex_branch_valid & ex_flush & ~squash_ex;
    assign pred_redirect = id_br & id_predict_taken & ~stall;
    // A mispredict must redirect even while the pipe is stalled.
    assign advance       = ~stall | mis;

    assign rq_push       = id_br & ~stall & ~mis;
    assign rq_pop        = ex_branch_valid & ~squash_ex;
    assign fallback_pc   = id_predict_taken ? (id_pc_q + PC_WIDTH'(PC_STEP)) : id_branch_target;
    assign rq_in         = '{fallback: RQ_DATA_WIDTH'(fallback_pc)};
    assign head_pc       = PC_WIDTH'(rq_head.fallback);

    recovery_queue #(
        .DEPTH (RQ_DEPTH)
    ) u_rq (
        .clk        (clk),
        .reset      (reset),
        .push       (rq_push),
        .push_entry (rq_in),
        .pop        (rq_pop),
        .clear      (mis),
        .full       (rq_full),
        .empty      (rq_empty),
        .head       (rq_head),
        .overflow   (rq_drop)
    );

    // Next fetch PC, flush strobes and stage PC tracking.
    always_comb begin
        pc_d        = pc_q;
        id_pc_d     = id_pc_q;
        ex_pc_d     = ex_pc_q;
        id_valid_d  = id_valid_q;
        ex_valid_d  = ex_valid_q;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ovf_d       = ovf_q | rq_drop;
        if (mis) begin
            pc_d        = head_pc;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (!stall) begin
            if (pred_redirect) begin
                pc_d        = id_branch_target;
                if_id_flush = 1'b1;
            end else begin
                pc_d = pc_q + PC_WIDTH'(PC_STEP);
            end
        end
        if (advance) begin
            id_pc_d    = pc_q;
            id_valid_d = ~if_id_flush;
            ex_pc_d    = id_pc_q;
            ex_valid_d = id_valid_q & ~id_ex_flush;
        end
    end

    // Squash FSM: masks the bubbles left behind by each redirect.
    always_comb begin
        state_d = state_q;
        if (mis) begin
            state_d = SQ_BOTH;
        end else if (!stall) begin
            case (state_q)
                RUN:     state_d = pred_redirect ? SQ_ID : RUN;
                SQ_ID:   state_d = RUN;
                SQ_BOTH: state_d = SQ_EX;
                SQ_EX:   state_d = pred_redirect ? SQ_ID : RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // Fetch/stage registers, FSM state and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            id_pc_q    <= '0;
            ex_pc_q    <= '0;
            id_valid_q <= 1'b0;
            ex_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            ex_pc_q    <= ex_pc_d;
            id_valid_q <= id_valid_d;
            ex_valid_q <= ex_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign pc          = pc_q;
    assign id_pc_idx   = id_pc_q[IDX_WIDTH+1:2];
    assign ex_pc_idx   = ex_pc_q[IDX_WIDTH+1:2];
    assign rq_overflow = ovf_q;

    assign unused_ok = ^{ex_pc_q[PC_WIDTH-1:IDX_WIDTH+2], ex_pc_q[1:0], ex_valid_q, rq_full, rq_empty};

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mis_q, stat_mis_d;

    // Saturating resolved-branch and mispredict counters.
    always_comb begin
        stat_br_d  = stat_br_q;
        stat_mis_d = stat_mis_q;
        if (rq_pop && (stat_br_q != '1)) begin
            stat_br_d = stat_br_q + 32'd1;
        end
        if (mis && (stat_mis_q != '1)) begin
            stat_mis_d = stat_mis_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_br_q  <= stat_br_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// tb/tb_branch_redirect_unit.sv - self-checking bench for branch_redirect_unit
module tb_branch_redirect_unit;

`ifdef BRANCH_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif
    localparam logic [31:0] RST_PC = 32'h0;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        id_is_branch = 1'b0;
    logic        id_predict_taken = 1'b0;
    logic [31:0] id_branch_target = '0;
    logic        ex_branch_valid = 1'b0;
    logic        ex_flush = 1'b0;
    logic [31:0] pc;
    logic [2:0]  id_pc_idx;
    logic [2:0]  ex_pc_idx;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        rq_overflow;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int total = 0;
    int bad = 0;
    bit run_chk = 1'b0;

    branch_redirect_unit #(
        .PC_WIDTH  (32),
        .RESET_PC  (RST_PC),
        .IDX_WIDTH (3),
        .RQ_DEPTH  (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .id_is_branch     (id_is_branch),
        .id_predict_taken (id_predict_taken),
        .id_branch_target (id_branch_target),
        .ex_branch_valid  (ex_branch_valid),
        .ex_flush         (ex_flush),
        .pc               (pc),
        .id_pc_idx        (id_pc_idx),
        .ex_pc_idx        (ex_pc_idx),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .rq_overflow      (rq_overflow),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pipeline as plain values, queue of fallbacks, squash windows as counters.
    logic [31:0] m_pc, m_id, m_ex, m_br, m_mis;
    logic [31:0] mq[$];
    bit          m_ovf;
    int          id_win, ex_win;

    task automatic model_reset();
        m_pc = RST_PC; m_id = 0; m_ex = 0; m_br = 0; m_mis = 0;
        mq.delete(); m_ovf = 0; id_win = 0; ex_win = 0;
    endtask

    function automatic logic [31:0] idx_of(input logic [31:0] a);
        return (a >> 2) % 8;
    endfunction

    always @(negedge clk) begin
        if (run_chk) begin
            bit sq_id, sq_ex, e_br, e_mis, e_pt, e_pop, e_push;
            logic [31:0] npc;
            if (!reset) model_reset();
            sq_id = id_win > 0;
            sq_ex = ex_win > 0;
            e_br  = id_is_branch && !sq_id;
            e_mis = ex_branch_valid && ex_flush && !sq_ex;
            e_pt  = e_br && id_predict_taken && !stall;
            chk("pc", pc, m_pc);
            chk("id_pc_idx", id_pc_idx, idx_of(m_id));
            chk("ex_pc_idx", ex_pc_idx, idx_of(m_ex));
            chk("if_id_flush", if_id_flush, e_mis || e_pt);
            chk("id_ex_flush", id_ex_flush, e_mis);
            chk("rq_overflow", rq_overflow, m_ovf);
            chk("stat_branches", stat_branches, STATS_ON ? m_br : 0);
            chk("stat_mispredicts", stat_mispredicts, STATS_ON ? m_mis : 0);
            if (reset) begin
                e_pop  = ex_branch_valid && !sq_ex;
                e_push = e_br && !stall && !e_mis;
                if (e_mis) npc = (mq.size() > 0) ? mq[0] : m_pc;
                else if (stall) npc = m_pc;
                else if (e_pt) npc = id_branch_target;
                else npc = m_pc + 4;
                if (e_pop && m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
                if (e_mis && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
                if (e_mis) begin
                    mq.delete();
                end else begin
                    if (e_pop && mq.size() > 0) void'(mq.pop_front());
                    if (e_push) begin
                        if (mq.size() < DEPTH) mq.push_back(id_predict_taken ? m_id + 4 : id_branch_target);
                        else m_ovf = 1;
                    end
                end
                if (!stall || e_mis) begin
                    m_ex = m_id;
                    m_id = m_pc;
                end
                if (e_mis) begin
                    id_win = 1; ex_win = 2;
                end else if (!stall) begin
                    if (id_win > 0) id_win--;
                    if (ex_win > 0) ex_win--;
                    if (e_pt) id_win = 1;
                end
                m_pc = npc;
            end
        end
    end

    task automatic cyc(input logic st, input logic ib, input logic pr, input logic [31:0] tg,
                       input logic ev, input logic ef);
        @(posedge clk);
        #2;
        stall = st; id_is_branch = ib; id_predict_taken = pr;
        id_branch_target = tg; ex_branch_valid = ev; ex_flush = ef;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        run_chk = 1'b1;
        chk("reset_pc", pc, RST_PC);
        release_reset();                         // cycle 0: pc = 0
        idle(3);
        chk("seq_pc_c", pc, 32'h0C);
        idle(1);
        cyc(0, 1, 1, 32'h40, 0, 0);              // branch at 0x10 predicted taken
        chk("pt_flush", if_id_flush, 1);
        cyc(0, 1, 1, 32'h100, 1, 1);             // ID branch squashed, EX mispredict
        chk("pt_pc", pc, 32'h40);
        chk("ex_idx_br", ex_pc_idx, 3'd4);
        chk("mis_if_id", if_id_flush, 1);
        chk("mis_id_ex", id_ex_flush, 1);
        cyc(0, 1, 1, 32'h200, 1, 1);             // squashed in both stages
        chk("mis_pc", pc, 32'h14);
        chk("sq_if_id", if_id_flush, 0);
        chk("sq_id_ex1", id_ex_flush, 0);
        cyc(0, 0, 0, 0, 1, 1);                   // EX still squashed
        chk("sq_id_ex2", id_ex_flush, 0);
        chk("sq_pc", pc, 32'h18);
        idle(2);
        cyc(0, 1, 0, 32'h80, 0, 0);              // branch at 0x20 predicted not-taken
        chk("nt_pc", pc, 32'h24);
        chk("nt_flush", if_id_flush, 0);
        cyc(1, 0, 0, 0, 1, 1);                   // mispredict under stall
        chk("stmis_if_id", if_id_flush, 1);
        chk("stmis_id_ex", id_ex_flush, 1);
        idle(1);
        chk("stmis_pc", pc, 32'h80);
        idle(2);
        cyc(0, 1, 0, 32'h200, 0, 0);             // three pushes into a two-entry queue
        cyc(0, 1, 0, 32'h300, 0, 0);
        cyc(0, 1, 0, 32'h400, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("ovf_set", rq_overflow, 1);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 1, 32'hFFFF_FFFC, 0, 0);       // redirect to top of address space
        chk("ovf_sticky", rq_overflow, 1);
        chk("pre_wrap_pc", pc, 32'hA4);
        chk("stat_br_lit", stat_branches, STATS_ON ? 32'd5 : 32'd0);
        chk("stat_mis_lit", stat_mispredicts, STATS_ON ? 32'd2 : 32'd0);
        idle(1);
        chk("top_pc", pc, 32'hFFFF_FFFC);
        idle(1);
        chk("wrap_pc", pc, 32'h0);
        cyc(0, 1, 1, 32'h300, 0, 0);
        chk("pt2_flush", if_id_flush, 1);
        idle(1);
        chk("pt2_pc", pc, 32'h300);
        #1;
        reset = 1'b0;                            // asynchronous reset mid-redirect
        #1;
        chk("async_pc", pc, RST_PC);
        chk("async_ovf", rq_overflow, 0);
        chk("async_idx", id_pc_idx, 0);
        chk("async_flush", if_id_flush, 0);
        release_reset();
        idle(11);
        cyc(1, 0, 0, 0, 0, 0);                   // pc = 0x30, stalled
        cyc(1, 0, 0, 0, 0, 0);
        chk("stall_pc1", pc, 32'h30);
        idle(1);
        chk("stall_pc2", pc, 32'h30);
        idle(1);
        chk("resume_pc", pc, 32'h34);
        @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Fetch-side consumer of the 2-bit branch predictor's control signals. Owns the fetch PC register and tracks the PC of the instruction in ID and in ALU/EX. It supplies the predictor's 3-bit table indices and applies its decisions: predicted-taken redirect from ID, and mispredict recovery from EX using a small recovery queue. It also generates the IF/ID and ID/EX flushes, with a squash FSM that masks bubble stages after each redirect.

## Interface
- PC_WIDTH, 32, fetch address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IDX_WIDTH, 3, predictor index width; index = pc[IDX_WIDTH+1:2]
- RQ_DEPTH, 2, recovery queue entries

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- stall  in  1  hazard stall; hold PC, stage PCs, FSM state
- id_is_branch  in  1  conditional branch in ID
- id_predict_taken  in  1  predictor's take-branch decision for ID branch
- id_branch_target  in  PC_WIDTH  id_pc + B-imm from ID adder
- ex_branch_valid  in  1  branch resolved in ALU stage
- ex_flush  in  1  predictor reports mispredict
- pc  out  PC_WIDTH  fetch address
- id_pc_idx  out  IDX_WIDTH  predictor index of ID instruction
- ex_pc_idx  out  IDX_WIDTH  predictor index of EX instruction
- if_id_flush  out  1  clear IF/ID at next edge
- id_ex_flush  out  1  clear ID/EX at next edge
- rq_overflow  out  1  sticky error: push attempted on full queue

## Operation
- Stage PC tracking: on advance (no stall), id_pc <= pc and ex_pc <= id_pc. On if_id_flush, id_pc is marked invalid. On id_ex_flush, ex_pc is marked invalid.
- Effective events are inputs gated by FSM:
  - id_br = id_is_branch & ~squash_id
  - mis = ex_branch_valid & ex_flush & ~squash_ex
- Recovery queue:
  - Push on id_br & ~stall & ~mis.
  - Entry fallback = id_predict_taken ? id_pc+4 : id_branch_target.
  - Pop on ex_branch_valid & ~squash_ex.
  - Cleared entirely on mis.
  - Push when full: entry dropped, rq_overflow set.
  - Pop when empty: no-op.
  - Simultaneous push and pop: both occur; count unchanged.
- Next-PC priority, highest first:
  1. mis: pc <= head fallback; if_id_flush = id_ex_flush = 1. Overrides stall.
  2. stall: everything holds.
  3. id_br & id_predict_taken: pc <= id_branch_target; if_id_flush = 1.
  4. otherwise: pc <= pc + 4, wrapping modulo 2^PC_WIDTH.
- Flushes are combinational from the current-cycle inputs and state.
- FSM states:
  - RUN: no squash.
  - SQ_ID: squash_id.
  - SQ_BOTH: squash_id and squash_ex.
  - SQ_EX: squash_ex.
- FSM transitions (no transition while stall, except on mis):
  - RUN: mis -> SQ_BOTH; else predicted-taken -> SQ_ID.
  - SQ_ID -> RUN.
  - SQ_BOTH -> SQ_EX.
  - SQ_EX -> SQ_ID if predicted-taken, else RUN.

## Timing
- Reset values:
  - pc = RESET_PC
  - id_pc_idx = ex_pc_idx = 0
  - stage valids = 0
  - queue empty
  - state = RUN
  - flushes = 0
  - rq_overflow = 0
- Redirect latency: the new pc is visible the cycle after the triggering input.
- Misprediction penalty: 2 bubbles. Predicted-taken penalty: 1 bubble.
- Reset asserted mid-redirect: all state returns to reset values immediately; no partial update is kept.
- Stall and mis in the same cycle: mis wins; the stall is not honoured that cycle.

## Configuration
- BRANCH_STATS_EN defined:
  - Adds 32-bit outputs stat_branches and stat_mispredicts.
  - stat_branches increments on every pop; stat_mispredicts increments on every mis.
  - Both saturate at all-ones and reset to 0.
- BRANCH_STATS_EN undefined: both outputs exist and are tied to 0; no counter flops.

## Structure
- Shared package branch_pkg holds:
  - the FSM state enum (RUN, SQ_ID, SQ_BOTH, SQ_EX)
  - the rq_entry_t struct {fallback}
  - the PC_STEP = 4 constant
- Sub-module recovery_queue: a parameterised circular FIFO with push, pop, clear, full, empty and head.

## Test plan
- Reset release with no branches -> pc follows 0, 4, 8, …; flushes stay 0; id_pc_idx cycles 0..7.
- Branch at 0x10 predicted taken, target 0x40 -> next cycle pc = 0x40, if_id_flush pulses 1 cycle; the following ID branch is ignored.
- Same branch resolves in EX with ex_flush = 1 -> pc = 0x14, both flushes pulse, queue empties, EX inputs ignored 2 cycles.
- Branch at 0x20 predicted not-taken (target 0x80) with EX mispredict asserted while stall = 1 -> pc = 0x80 next cycle.
- Three pushes with no pops (RQ_DEPTH = 2) -> rq_overflow = 1 and stays set until reset; assert reset mid-sequence -> pc = RESET_PC asynchronously.
- With BRANCH_STATS_EN, 5 resolved branches including 2 mispredicts -> stat_branches = 5, stat_mispredicts = 2.
